// File: rtl/box_compositor_pkg.sv
// Shared display types and constants for the box compositor.
// Colour pick is kept here so the stage-2 mux reads as one call.
package box_compositor_pkg;

  localparam int COORD_W = 12;
  localparam int RGB_W   = 12;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [RGB_W-1:0]   rgb_t;

  localparam rgb_t RGB_BLACK = '0;

  typedef struct packed {
    logic hit_a;
    logic hit_b;
    logic active;
  } s1_t;

  // Box A wins over box B; inactive pixels are always black.
  function automatic rgb_t pick_rgb(
    input s1_t  s,
    input rgb_t col_a,
    input rgb_t col_b,
    input rgb_t col_bg
  );
    rgb_t c;
    c = RGB_BLACK;
    if (s.active) begin
      if (s.hit_a)      c = col_a;
      else if (s.hit_b) c = col_b;
      else              c = col_bg;
    end
    return c;
  endfunction

endpackage

// File: rtl/box_compositor_if.sv
// Scan-in, box coordinate and composited-pixel-out bundle.
// master drives scan and coordinates; slave is the compositor.
interface box_compositor_if;
  import box_compositor_pkg::*;

  logic        i_pix_stb;
  logic [9:0]  i_x;
  logic [8:0]  i_y;
  logic        i_active;
  logic        i_frame;

  coord_t      i_a_x1, i_a_x2, i_a_y1, i_a_y2;
  coord_t      i_b_x1, i_b_x2, i_b_y1, i_b_y2;

  rgb_t        o_rgb;
  logic        o_rgb_valid;
  logic        o_latched;
  logic        o_collide;
  logic        o_collide_stb;

  modport master (
    output i_pix_stb, i_x, i_y, i_active, i_frame,
    output i_a_x1, i_a_x2, i_a_y1, i_a_y2,
    output i_b_x1, i_b_x2, i_b_y1, i_b_y2,
    input  o_rgb, o_rgb_valid, o_latched,
    input  o_collide, o_collide_stb
  );

  modport slave (
    input  i_pix_stb, i_x, i_y, i_active, i_frame,
    input  i_a_x1, i_a_x2, i_a_y1, i_a_y2,
    input  i_b_x1, i_b_x2, i_b_y1, i_b_y2,
    output o_rgb, o_rgb_valid, o_latched,
    output o_collide, o_collide_stb
  );

endinterface

// File: rtl/box_compositor_box_hit.sv
// Per-box shadow coordinates plus inclusive unsigned hit test.
// Reset leaves the box empty (x1>x2, y1>y2) until the first capture.
module box_hit
  import box_compositor_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_cap,
  input  coord_t i_x1,
  input  coord_t i_x2,
  input  coord_t i_y1,
  input  coord_t i_y2,
  input  coord_t i_x,
  input  coord_t i_y,
  output logic   o_hit
);

  coord_t x1, x2, y1, y2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x1 <= coord_t'(1);
      x2 <= '0;
      y1 <= coord_t'(1);
      y2 <= '0;
    end else if (i_cap) begin
      x1 <= i_x1;
      x2 <= i_x2;
      y1 <= i_y1;
      y2 <= i_y2;
    end
  end

  assign o_hit = (i_x >= x1) && (i_x <= x2) &&
                 (i_y >= y1) && (i_y <= y2);

endmodule

// File: rtl/box_compositor.sv
// Two-box compositor: 2-stage pixel pipeline plus per-frame
// A/B collision flag reported at each start of frame.
module box_compositor
  import box_compositor_pkg::*;
#(
  parameter rgb_t COL_A  = 12'hF00,
  parameter rgb_t COL_B  = 12'h0F0,
  parameter rgb_t COL_BG = 12'h00F
) (
  input logic             i_clk,
  input logic             i_rst,
  box_compositor_if.slave bus
);

  coord_t x, y;
  logic   cap;
  logic   hit_a, hit_b;
  logic   overlap;
  logic   acc;
  s1_t    s1;

  rgb_t   rgb_q;
  logic   valid_q;
  logic   latched_q;
  logic   collide_q;
  logic   collide_stb_q;

  assign x   = coord_t'(bus.i_x);
  assign y   = coord_t'(bus.i_y);
  assign cap = bus.i_frame && bus.i_pix_stb;

  box_hit u_hit_a (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_cap (cap),
    .i_x1  (bus.i_a_x1),
    .i_x2  (bus.i_a_x2),
    .i_y1  (bus.i_a_y1),
    .i_y2  (bus.i_a_y2),
    .i_x   (x),
    .i_y   (y),
    .o_hit (hit_a)
  );

  box_hit u_hit_b (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_cap (cap),
    .i_x1  (bus.i_b_x1),
    .i_x2  (bus.i_b_x2),
    .i_y1  (bus.i_b_y1),
    .i_y2  (bus.i_b_y2),
    .i_x   (x),
    .i_y   (y),
    .o_hit (hit_b)
  );

  assign overlap = s1.hit_a && s1.hit_b && s1.active;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1            <= '0;
      rgb_q         <= RGB_BLACK;
      valid_q       <= 1'b0;
      latched_q     <= 1'b0;
      collide_q     <= 1'b0;
      collide_stb_q <= 1'b0;
      acc           <= 1'b0;
    end else begin
      latched_q     <= 1'b0;
      collide_stb_q <= 1'b0;
      if (bus.i_pix_stb) begin
        s1      <= '{hit_a: hit_a, hit_b: hit_b,
                     active: bus.i_active};
        rgb_q   <= pick_rgb(s1, COL_A, COL_B, COL_BG);
        valid_q <= s1.active;
        // Frame clear wins over a same-strobe accumulate.
        if (bus.i_frame) begin
          collide_q     <= acc || overlap;
          collide_stb_q <= 1'b1;
          latched_q     <= 1'b1;
          acc           <= 1'b0;
        end else if (overlap) begin
          acc <= 1'b1;
        end
      end
    end
  end

  assign bus.o_rgb         = rgb_q;
  assign bus.o_rgb_valid   = valid_q;
  assign bus.o_latched     = latched_q;
  assign bus.o_collide     = collide_q;
  assign bus.o_collide_stb = collide_stb_q;

endmodule

// File: tb/tb_box_compositor.sv
// Bench for box_compositor: directed scenarios plus random scan
// checked against a frame-level colour/collision model.
module tb_box_compositor;

  localparam logic [11:0] COL_A  = 12'hF00;
  localparam logic [11:0] COL_B  = 12'h0F0;
  localparam logic [11:0] COL_BG = 12'h00F;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  box_compositor_if bus();

  box_compositor dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model state: captured boxes, pixels in flight, frame overlap.
  int a_in[4], b_in[4];
  int ma[4], mb[4];
  logic [12:0] q[$];
  bit frame_ov;
  logic [11:0] exp_rgb;
  bit exp_valid, exp_lat, exp_col, exp_cstb;

  function automatic bit inbox(int x, int y, int c0, int c1,
                               int c2, int c3);
    return x >= c0 && x <= c1 && y >= c2 && y <= c3;
  endfunction

  task automatic model_reset();
    ma = '{1, 0, 1, 0};
    mb = '{1, 0, 1, 0};
    q.delete();
    q.push_back(13'h0);
    frame_ov = 0;
    exp_rgb = 0; exp_valid = 0;
    exp_lat = 0; exp_col = 0; exp_cstb = 0;
  endtask

  task automatic model(input bit r, input bit stb, input int x,
                       input int y, input bit act, input bit frm);
    bit ha, hb;
    logic [11:0] c;
    exp_lat = 0;
    exp_cstb = 0;
    if (r) begin
      model_reset();
      return;
    end
    if (!stb) return;
    ha = act && inbox(x, y, ma[0], ma[1], ma[2], ma[3]);
    hb = act && inbox(x, y, mb[0], mb[1], mb[2], mb[3]);
    c = !act ? 12'h000 : ha ? COL_A : hb ? COL_B : COL_BG;
    q.push_back({act, c});
    {exp_valid, exp_rgb} = q.pop_front();
    if (frm) begin
      exp_col = frame_ov;
      frame_ov = 0;
      exp_cstb = 1;
      exp_lat = 1;
      ma = a_in;
      mb = b_in;
    end else if (ha && hb) begin
      frame_ov = 1;
    end
  endtask

  task automatic set_boxes(input int a0, a1, a2, a3,
                           input int b0, b1, b2, b3);
    a_in = '{a0, a1, a2, a3};
    b_in = '{b0, b1, b2, b3};
    bus.i_a_x1 = 12'(a0); bus.i_a_x2 = 12'(a1);
    bus.i_a_y1 = 12'(a2); bus.i_a_y2 = 12'(a3);
    bus.i_b_x1 = 12'(b0); bus.i_b_x2 = 12'(b1);
    bus.i_b_y1 = 12'(b2); bus.i_b_y2 = 12'(b3);
  endtask

  task automatic step(input bit stb, input int x, input int y,
                      input bit act, input bit frm);
    bus.i_pix_stb = stb;
    bus.i_x = 10'(x);
    bus.i_y = 9'(y);
    bus.i_active = act;
    bus.i_frame = frm;
    @(posedge clk);
    model(rst, stb, x, y, act, frm);
    #1;
  endtask

  task automatic rand_pix(input int n, input int maxc);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, maxc),
           $urandom_range(0, maxc), $urandom_range(0, 7) != 0, 0);
      if ({bus.o_rgb_valid, bus.o_rgb} !== {exp_valid, exp_rgb}) begin
        miscompares++;
        $display("FAIL rand_pix t=%0t got %b/%h exp %b/%h", $time,
                 bus.o_rgb_valid, bus.o_rgb, exp_valid, exp_rgb);
      end
      vectors++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1, 5, 5, 0, 1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_boxes(0, 400, 0, 400, 0, 400, 0, 400);
    do_reset();
    if ({bus.o_rgb_valid, bus.o_rgb, bus.o_latched, bus.o_collide,
         bus.o_collide_stb} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_outs got %b/%h/%b/%b/%b exp all 0",
               bus.o_rgb_valid, bus.o_rgb, bus.o_latched,
               bus.o_collide, bus.o_collide_stb);
    end
    vectors++;
    step(0, 0, 0, 0, 0);
    if ({bus.o_latched, bus.o_collide_stb} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_idle got lat=%b cstb=%b exp 0/0",
               bus.o_latched, bus.o_collide_stb);
    end
    vectors++;
  endtask

  task automatic test_no_frame();
    for (int i = 0; i < 60; i++) begin
      step(1, $urandom_range(0, 400), $urandom_range(0, 400),
           $urandom_range(0, 1), 0);
      if (bus.o_rgb_valid && bus.o_rgb !== COL_BG) begin
        miscompares++;
        $display("FAIL no_frame_bg got %h exp %h", bus.o_rgb, COL_BG);
      end
      if (bus.o_collide !== 1'b0) begin
        miscompares++;
        $display("FAIL no_frame_collide got %b exp 0", bus.o_collide);
      end
      vectors += 2;
    end
  endtask

  task automatic test_box_a();
    set_boxes(100, 200, 100, 200, 1, 0, 1, 0);
    step(1, 0, 0, 0, 1);
    if (bus.o_latched !== 1'b1) begin
      miscompares++;
      $display("FAIL box_a_latched got %b exp 1", bus.o_latched);
    end
    vectors++;
    step(1, 100, 100, 1, 0);
    step(1, 201, 100, 1, 0);
    if ({bus.o_rgb_valid, bus.o_rgb} !== {1'b1, COL_A}) begin
      miscompares++;
      $display("FAIL box_a_hit got %b/%h exp 1/%h",
               bus.o_rgb_valid, bus.o_rgb, COL_A);
    end
    step(0, 0, 0, 0, 0);
    if (bus.o_rgb !== COL_A) begin
      miscompares++;
      $display("FAIL box_a_hold got %h exp %h", bus.o_rgb, COL_A);
    end
    step(1, 200, 200, 1, 0);
    if (bus.o_rgb !== COL_BG) begin
      miscompares++;
      $display("FAIL box_a_miss got %h exp %h", bus.o_rgb, COL_BG);
    end
    step(1, 0, 0, 0, 0);
    if (bus.o_rgb !== COL_A) begin
      miscompares++;
      $display("FAIL box_a_corner got %h exp %h", bus.o_rgb, COL_A);
    end
    vectors += 4;
  endtask

  task automatic test_collision();
    set_boxes(100, 200, 100, 200, 150, 250, 150, 250);
    step(1, 0, 0, 0, 1);
    rand_pix(150, 300);
    step(1, 160, 160, 1, 0);
    step(1, 0, 0, 0, 0);
    if (bus.o_rgb !== COL_A) begin
      miscompares++;
      $display("FAIL coll_prio got %h exp %h", bus.o_rgb, COL_A);
    end
    set_boxes(100, 200, 100, 200, 300, 400, 300, 400);
    step(1, 0, 0, 0, 1);
    if ({bus.o_collide, bus.o_collide_stb} !== 2'b11) begin
      miscompares++;
      $display("FAIL coll_set got %b/%b exp 1/1",
               bus.o_collide, bus.o_collide_stb);
    end
    step(0, 0, 0, 0, 0);
    if (bus.o_collide_stb !== 1'b0) begin
      miscompares++;
      $display("FAIL coll_pulse got %b exp 0", bus.o_collide_stb);
    end
    rand_pix(150, 299);
    step(1, 0, 0, 0, 1);
    if ({bus.o_collide, bus.o_collide_stb} !== 2'b01) begin
      miscompares++;
      $display("FAIL coll_clear got %b/%b exp 0/1",
               bus.o_collide, bus.o_collide_stb);
    end
    vectors += 4;
  endtask

  task automatic test_midframe();
    int pulses;
    pulses = 0;
    set_boxes(10, 50, 10, 50, 1, 0, 1, 0);
    step(1, 0, 0, 0, 1);
    pulses += int'(bus.o_latched);
    set_boxes(300, 310, 300, 310, 20, 30, 20, 30);
    for (int i = 0; i < 80; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 60),
           $urandom_range(0, 60), 1, 0);
      pulses += int'(bus.o_latched);
      if ({bus.o_rgb_valid, bus.o_rgb} !== {exp_valid, exp_rgb}) begin
        miscompares++;
        $display("FAIL mid_render got %h exp %h", bus.o_rgb, exp_rgb);
      end
      vectors++;
    end
    step(1, 25, 25, 1, 0);
    step(1, 0, 0, 0, 0);
    if (bus.o_rgb !== COL_A) begin
      miscompares++;
      $display("FAIL mid_old_box got %h exp %h", bus.o_rgb, COL_A);
    end
    step(1, 0, 0, 0, 1);
    pulses += int'(bus.o_latched);
    step(1, 25, 25, 1, 0);
    step(1, 0, 0, 0, 0);
    pulses += int'(bus.o_latched);
    if (bus.o_rgb !== COL_B) begin
      miscompares++;
      $display("FAIL mid_new_box got %h exp %h", bus.o_rgb, COL_B);
    end
    if (pulses !== 2) begin
      miscompares++;
      $display("FAIL mid_latch_count got %0d exp 2", pulses);
    end
    vectors += 3;
  endtask

  task automatic test_inverted();
    set_boxes(500, 20, 0, 479, 1, 0, 1, 0);
    step(1, 0, 0, 0, 1);
    step(1, 10, 50, 1, 0);
    step(1, 300, 50, 1, 0);
    if (bus.o_rgb !== COL_BG) begin
      miscompares++;
      $display("FAIL inv_lo got %h exp %h", bus.o_rgb, COL_BG);
    end
    step(1, 0, 0, 0, 0);
    if (bus.o_rgb !== COL_BG) begin
      miscompares++;
      $display("FAIL inv_hi got %h exp %h", bus.o_rgb, COL_BG);
    end
    vectors += 2;
  endtask

  task automatic test_reset_midframe();
    set_boxes(0, 100, 0, 100, 0, 100, 0, 100);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 50, 50, 1, 0);
    do_reset();
    for (int i = 0; i < 30; i++) begin
      step(1, $urandom_range(0, 200), $urandom_range(0, 200), 1, 0);
      if (bus.o_collide_stb !== 1'b0) begin
        miscompares++;
        $display("FAIL rstmid_stb got %b exp 0", bus.o_collide_stb);
      end
      vectors++;
    end
    step(1, 0, 0, 0, 1);
    if ({bus.o_collide, bus.o_collide_stb} !== 2'b01) begin
      miscompares++;
      $display("FAIL rstmid_collide got %b/%b exp 0/1",
               bus.o_collide, bus.o_collide_stb);
    end
    vectors++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 4) begin
        set_boxes($urandom_range(0, 300), $urandom_range(0, 300),
                  $urandom_range(0, 300), $urandom_range(0, 300),
                  $urandom_range(0, 300), $urandom_range(0, 300),
                  $urandom_range(0, 300), $urandom_range(0, 300));
      end
      rst = (r == 5);
      if (r >= 190)
        step($urandom_range(0, 1), 0, 0, 0, 1);
      else
        step($urandom_range(0, 3) != 0, $urandom_range(0, 320),
             $urandom_range(0, 320), $urandom_range(0, 5) != 0, 0);
      rst = 1'b0;
      if ({bus.o_rgb_valid, bus.o_rgb, bus.o_latched, bus.o_collide,
           bus.o_collide_stb} !==
          {exp_valid, exp_rgb, exp_lat, exp_col, exp_cstb}) begin
        miscompares++;
        $display("FAIL random t=%0t got %b/%h/%b/%b/%b exp %b/%h/%b/%b/%b",
                 $time, bus.o_rgb_valid, bus.o_rgb, bus.o_latched,
                 bus.o_collide, bus.o_collide_stb, exp_valid, exp_rgb,
                 exp_lat, exp_col, exp_cstb);
      end
      vectors++;
    end
  endtask

  initial begin
    bus.i_pix_stb = 0;
    bus.i_x = 0;
    bus.i_y = 0;
    bus.i_active = 0;
    bus.i_frame = 0;
    set_boxes(1, 0, 1, 0, 1, 0, 1, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_no_frame();
    test_box_a();
    test_collision();
    test_midframe();
    test_inverted();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
